// File: rtl/cpu_dbg_pkg.sv
// Shared encodings for the cpu debug run controller: command opcodes and run states.
package cpu_dbg_pkg;

  typedef enum logic [1:0] {
    OP_HALT  = 2'd0,
    OP_RUN   = 2'd1,
    OP_STEP  = 2'd2,
    OP_RUN_N = 2'd3
  } cmd_op_e;

  typedef enum logic [1:0] {
    ST_HALTED = 2'd0,
    ST_RUN    = 2'd1,
    ST_COUNT  = 2'd2
  } run_state_e;

endpackage

// File: rtl/bp_match_unit.sv
// Parallel PC breakpoint comparators; purely combinational.
module bp_match_unit #(
  parameter int unsigned PC_W   = 32,
  parameter int unsigned NUM_BP = 2
) (
  input  logic [PC_W-1:0]        pc,
  input  logic [NUM_BP*PC_W-1:0] bp_addr,
  input  logic [NUM_BP-1:0]      bp_en,
  output logic [NUM_BP-1:0]      bp_match
);

  always_comb begin
    bp_match = '0;
    for (int i = 0; i < NUM_BP; i++) begin
      bp_match[i] = bp_en[i] && (pc == bp_addr[i*PC_W +: PC_W]);
    end
  end

endmodule

// File: rtl/cpu_run_ctrl.sv
// Run/step controller producing the cpu clock-enable, with PC breakpoints,
// bounded runs and a saturating enabled-cycle counter.
module cpu_run_ctrl
  import cpu_dbg_pkg::*;
#(
  parameter int unsigned PC_W   = 32,
  parameter int unsigned CNT_W  = 32,
  parameter int unsigned NUM_BP = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cmd_valid,
  input  logic [1:0]             cmd_op,
  input  logic [CNT_W-1:0]       cmd_n,
  input  logic [PC_W-1:0]        pc,
  input  logic [NUM_BP*PC_W-1:0] bp_addr,
  input  logic [NUM_BP-1:0]      bp_en,
  output logic                   cpu_ce,
  output logic                   cmd_ready,
  output logic [1:0]             run_state,
  output logic                   done,
  output logic [NUM_BP-1:0]      bp_hit,
  output logic [CNT_W-1:0]       cycle_cnt
);

  run_state_e        state_q;
  logic [CNT_W-1:0]  remaining_q;
  logic              bp_mask_q;
  logic [CNT_W-1:0]  cycle_cnt_q;
  logic [NUM_BP-1:0] bp_hit_q;
  logic              done_q;

  logic [NUM_BP-1:0] bp_match;
  logic              running;
  logic              brk;
  cmd_op_e           op;

  bp_match_unit #(
    .PC_W   (PC_W),
    .NUM_BP (NUM_BP)
  ) u_bp_match (
    .pc       (pc),
    .bp_addr  (bp_addr),
    .bp_en    (bp_en),
    .bp_match (bp_match)
  );

  assign op      = cmd_op_e'(cmd_op);
  assign running = (state_q != ST_HALTED);
  // The mask lets a resumed run execute the instruction it is parked on.
  assign brk     = running && (|bp_match) && !bp_mask_q;
  assign cpu_ce  = running && !brk;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_HALTED;
      remaining_q <= '0;
      bp_mask_q   <= 1'b0;
      cycle_cnt_q <= '0;
      bp_hit_q    <= '0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (cpu_ce && (cycle_cnt_q != {CNT_W{1'b1}})) begin
        cycle_cnt_q <= cycle_cnt_q + CNT_W'(1);
      end
      if (running) begin
        bp_mask_q <= 1'b0;
      end

      // A command always overrides a coincident breakpoint or count expiry.
      if (cmd_valid) begin
        unique case (op)
          OP_HALT: begin
            state_q <= ST_HALTED;
            if (brk) begin
              bp_hit_q <= bp_hit_q | bp_match;
            end
          end
          OP_RUN: begin
            state_q   <= ST_RUN;
            bp_mask_q <= 1'b1;
            bp_hit_q  <= '0;
          end
          OP_STEP: begin
            state_q     <= ST_COUNT;
            remaining_q <= CNT_W'(1);
            bp_mask_q   <= 1'b1;
            bp_hit_q    <= '0;
          end
          OP_RUN_N: begin
            bp_hit_q <= '0;
            if (cmd_n == '0) begin
              state_q <= ST_HALTED;
              done_q  <= 1'b1;
            end else begin
              state_q     <= ST_COUNT;
              remaining_q <= cmd_n;
              bp_mask_q   <= 1'b1;
            end
          end
        endcase
      end else if (brk) begin
        state_q  <= ST_HALTED;
        bp_hit_q <= bp_hit_q | bp_match;
        done_q   <= 1'b1;
      end else if ((state_q == ST_COUNT) && cpu_ce) begin
        remaining_q <= remaining_q - CNT_W'(1);
        if (remaining_q == CNT_W'(1)) begin
          state_q <= ST_HALTED;
          done_q  <= 1'b1;
        end
      end
    end
  end

  assign cmd_ready = 1'b1;
  assign run_state = state_q;
  assign done      = done_q;
  assign bp_hit    = bp_hit_q;
  assign cycle_cnt = cycle_cnt_q;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Bench for cpu_run_ctrl: per-cycle vector table through a scoreboard queue,
// plus hand sequences for asynchronous reset and counter saturation.
module tb_cpu_run_ctrl;

  localparam int unsigned PC_W   = 32;
  localparam int unsigned NUM_BP = 2;

  localparam logic [1:0] H  = 2'd0;
  localparam logic [1:0] R  = 2'd1;
  localparam logic [1:0] S  = 2'd2;
  localparam logic [1:0] RN = 2'd3;

  typedef struct {
    logic        v;
    logic [1:0]  op;
    logic [31:0] n;
    logic [31:0] pc;
    logic [1:0]  en;
    logic [31:0] bp0;
    logic        ce;
    logic        dn;
    logic [1:0]  st;
    logic [1:0]  hit;
    logic [31:0] cnt;
  } vec_t;

  typedef struct {
    logic        ce;
    logic        dn;
    logic [1:0]  st;
    logic [1:0]  hit;
    logic [31:0] cnt;
  } exp_t;

  logic                   clk;
  logic                   rst;
  logic                   cmd_valid;
  logic [1:0]             cmd_op;
  logic [31:0]            cmd_n;
  logic [PC_W-1:0]        pc;
  logic [NUM_BP*PC_W-1:0] bp_addr;
  logic [NUM_BP-1:0]      bp_en;
  logic                   cpu_ce;
  logic                   cmd_ready;
  logic [1:0]             run_state;
  logic                   done;
  logic [NUM_BP-1:0]      bp_hit;
  logic [31:0]            cycle_cnt;

  logic                   cmd_valid4;
  logic [1:0]             cmd_op4;
  logic [3:0]             cmd_n4;
  logic                   cpu_ce4;
  logic                   cmd_ready4;
  logic [1:0]             run_state4;
  logic                   done4;
  logic [NUM_BP-1:0]      bp_hit4;
  logic [3:0]             cycle_cnt4;

  int total = 0;
  int bad   = 0;

  vec_t vt[$];
  exp_t expq[$];

  cpu_run_ctrl #(.PC_W(PC_W), .CNT_W(32), .NUM_BP(NUM_BP)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_op    (cmd_op),
    .cmd_n     (cmd_n),
    .pc        (pc),
    .bp_addr   (bp_addr),
    .bp_en     (bp_en),
    .cpu_ce    (cpu_ce),
    .cmd_ready (cmd_ready),
    .run_state (run_state),
    .done      (done),
    .bp_hit    (bp_hit),
    .cycle_cnt (cycle_cnt)
  );

  cpu_run_ctrl #(.PC_W(PC_W), .CNT_W(4), .NUM_BP(NUM_BP)) dut4 (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid4),
    .cmd_op    (cmd_op4),
    .cmd_n     (cmd_n4),
    .pc        ('0),
    .bp_addr   ('0),
    .bp_en     ('0),
    .cpu_ce    (cpu_ce4),
    .cmd_ready (cmd_ready4),
    .run_state (run_state4),
    .done      (done4),
    .bp_hit    (bp_hit4),
    .cycle_cnt (cycle_cnt4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic v, input logic [1:0] op, input logic [31:0] n,
                     input logic [31:0] p, input logic [1:0] en, input logic [31:0] b0,
                     input logic ce, input logic dn, input logic [1:0] st,
                     input logic [1:0] hit, input logic [31:0] cnt);
    vec_t x;
    x.v = v; x.op = op; x.n = n; x.pc = p; x.en = en; x.bp0 = b0;
    x.ce = ce; x.dn = dn; x.st = st; x.hit = hit; x.cnt = cnt;
    vt.push_back(x);
  endtask

  task automatic idle_inputs();
    cmd_valid = 1'b0; cmd_op = H; cmd_n = '0;
  endtask

  initial begin
    exp_t e;
    logic [31:0] exp4;

    // STEP from reset
    add(1, S,  0, 32'h00, 2'b00, 32'h10, 0, 0, 0, 2'b00, 0);
    add(0, H,  0, 32'h00, 2'b00, 32'h10, 1, 0, 2, 2'b00, 0);
    add(0, H,  0, 32'h00, 2'b00, 32'h10, 0, 1, 0, 2'b00, 1);
    add(0, H,  0, 32'h00, 2'b00, 32'h10, 0, 0, 0, 2'b00, 1);
    // RUN_N 5, then RUN_N 0
    add(1, RN, 5, 32'h00, 2'b00, 32'h10, 0, 0, 0, 2'b00, 1);
    for (int k = 0; k < 5; k++) add(0, H, 0, 32'h00, 2'b00, 32'h10, 1, 0, 2, 2'b00, 1 + k);
    add(0, H,  0, 32'h00, 2'b00, 32'h10, 0, 1, 0, 2'b00, 6);
    add(1, RN, 0, 32'h00, 2'b00, 32'h10, 0, 0, 0, 2'b00, 6);
    add(0, H,  0, 32'h00, 2'b00, 32'h10, 0, 1, 0, 2'b00, 6);
    add(0, H,  0, 32'h00, 2'b00, 32'h10, 0, 0, 0, 2'b00, 6);
    // RUN into slot-0 breakpoint at 0x10, then STEP over it
    add(1, R,  0, 32'h00, 2'b01, 32'h10, 0, 0, 0, 2'b00, 6);
    for (int k = 0; k < 4; k++) add(0, H, 0, 32'(4 * k), 2'b01, 32'h10, 1, 0, 1, 2'b00, 6 + k);
    add(0, H,  0, 32'h10, 2'b01, 32'h10, 0, 0, 1, 2'b00, 10);
    add(0, H,  0, 32'h10, 2'b01, 32'h10, 0, 1, 0, 2'b01, 10);
    add(1, S,  0, 32'h10, 2'b01, 32'h10, 0, 0, 0, 2'b01, 10);
    add(0, H,  0, 32'h10, 2'b01, 32'h10, 1, 0, 2, 2'b00, 10);
    add(0, H,  0, 32'h14, 2'b01, 32'h10, 0, 1, 0, 2'b00, 11);
    // both slots at 0x20
    add(1, R,  0, 32'h18, 2'b11, 32'h20, 0, 0, 0, 2'b00, 11);
    add(0, H,  0, 32'h18, 2'b11, 32'h20, 1, 0, 1, 2'b00, 11);
    add(0, H,  0, 32'h1c, 2'b11, 32'h20, 1, 0, 1, 2'b00, 12);
    add(0, H,  0, 32'h20, 2'b11, 32'h20, 0, 0, 1, 2'b00, 13);
    add(0, H,  0, 32'h20, 2'b11, 32'h20, 0, 1, 0, 2'b11, 13);
    // HALT coincident with a breakpoint: hit recorded, no done
    add(1, R,  0, 32'h1c, 2'b11, 32'h20, 0, 0, 0, 2'b11, 13);
    add(0, H,  0, 32'h1c, 2'b11, 32'h20, 1, 0, 1, 2'b00, 13);
    add(1, H,  0, 32'h20, 2'b11, 32'h20, 0, 0, 1, 2'b00, 14);
    add(0, H,  0, 32'h20, 2'b11, 32'h20, 0, 0, 0, 2'b11, 14);
    add(0, H,  0, 32'h04, 2'b11, 32'h20, 0, 0, 0, 2'b11, 14);

    rst = 1'b0;
    idle_inputs();
    pc = '0; bp_en = '0; bp_addr = '0;
    cmd_valid4 = 1'b0; cmd_op4 = H; cmd_n4 = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_ce", 32'(cpu_ce), 0);
    chk("reset_state", 32'(run_state), 0);
    chk("reset_cnt", cycle_cnt, 0);
    chk("reset_done", 32'(done), 0);
    chk("reset_hit", 32'(bp_hit), 0);
    chk("cmd_ready", 32'(cmd_ready), 1);
    rst = 1'b1;

    foreach (vt[i]) begin
      cmd_valid = vt[i].v; cmd_op = vt[i].op; cmd_n = vt[i].n;
      pc = vt[i].pc; bp_en = vt[i].en;
      bp_addr = {32'h20, vt[i].bp0};
      expq.push_back('{ce: vt[i].ce, dn: vt[i].dn, st: vt[i].st, hit: vt[i].hit,
                       cnt: vt[i].cnt});
      @(negedge clk);
      e = expq.pop_front();
      chk($sformatf("v%0d_ce", i), 32'(cpu_ce), 32'(e.ce));
      chk($sformatf("v%0d_done", i), 32'(done), 32'(e.dn));
      chk($sformatf("v%0d_state", i), 32'(run_state), 32'(e.st));
      chk($sformatf("v%0d_hit", i), 32'(bp_hit), 32'(e.hit));
      chk($sformatf("v%0d_cnt", i), cycle_cnt, e.cnt);
      @(posedge clk);
      #1;
    end

    // Asynchronous reset in the middle of RUN_N 10
    idle_inputs();
    bp_en = '0; pc = '0;
    cmd_valid = 1'b1; cmd_op = RN; cmd_n = 32'd10;
    @(posedge clk); #1;
    idle_inputs();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("pre_rst_ce", 32'(cpu_ce), 1);
    #1 rst = 1'b0;
    #1;
    chk("rst_ce", 32'(cpu_ce), 0);
    chk("rst_state", 32'(run_state), 0);
    chk("rst_cnt", cycle_cnt, 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_hit", 32'(bp_hit), 0);
    @(posedge clk); #1;
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("post_rst%0d_done", k), 32'(done), 0);
      chk($sformatf("post_rst%0d_ce", k), 32'(cpu_ce), 0);
    end

    // 4-bit counter saturation
    @(posedge clk); #1;
    cmd_valid4 = 1'b1; cmd_op4 = R;
    @(posedge clk); #1;
    cmd_valid4 = 1'b0;
    exp4 = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      chk($sformatf("sat%0d_ce", k), 32'(cpu_ce4), 1);
      chk($sformatf("sat%0d_cnt", k), 32'(cycle_cnt4), exp4);
      if (exp4 < 15) exp4++;
    end
    @(negedge clk);
    chk("sat_final", 32'(cycle_cnt4), 15);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cpu_run_ctrl.md
Name: cpu_run_ctrl

Overview:
Parametrised run/step controller that generates the clock-enable for the cpu core, replacing free-running and hand-toggled clocking in simulation and on the board.
- Modes: free RUN, single STEP, RUN_N cycles, and HALT.
- Up to NUM_BP PC breakpoints halt the core *before* the matching instruction executes.
- Also provides a saturating enabled-cycle counter and status for debug display.
- Sits between the top-level debug inputs and the cpu core's enable input.

Parameters:
- PC_W, 32, width of the cpu PC and of each breakpoint address.
- CNT_W, 32, width of the RUN_N count and of cycle_cnt.
- NUM_BP, 2, number of breakpoint comparators (≥1).

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command strobe; cmd_ready is always 1, so every strobe is accepted.
- cmd_op  in  2  0=HALT, 1=RUN, 2=STEP, 3=RUN_N.
- cmd_n  in  CNT_W  cycle count for RUN_N; ignored for other ops.
- pc  in  PC_W  cpu PC of the instruction that executes if cpu_ce=1 this cycle.
- bp_addr  in  NUM_BP*PC_W  breakpoint addresses; slot i = bits [i*PC_W +: PC_W].
- bp_en  in  NUM_BP  per-slot breakpoint enable.
- cpu_ce  out  1  cpu clock-enable for the current cycle.
- cmd_ready  out  1  constant 1.
- run_state  out  2  0=HALTED, 1=RUN, 2=COUNT.
- done  out  1  one-cycle pulse on an automatic halt.
- bp_hit  out  NUM_BP  sticky per-slot breakpoint hit flags.
- cycle_cnt  out  CNT_W  number of cycles with cpu_ce=1, saturating.

Behaviour:
- Reset (rst=0, async): run_state=HALTED, remaining=0, bp_mask=0, cycle_cnt=0, bp_hit=0, done=0. cpu_ce=0 while in reset.
- States:
  - HALTED: core frozen.
  - RUN: enabled indefinitely.
  - COUNT: enabled for `remaining` more cycles.
- Command acceptance (cmd_valid=1), effective next cycle; a command overrides any current state:
  - HALT → HALTED; no done pulse.
  - RUN → RUN; bp_mask=1; bp_hit cleared.
  - STEP → COUNT with remaining=1; bp_mask=1; bp_hit cleared.
  - RUN_N, cmd_n>0 → COUNT with remaining=cmd_n; bp_mask=1; bp_hit cleared.
  - RUN_N, cmd_n=0 → HALTED; done pulses next cycle; bp_hit cleared.
- Latency: exactly 1 cycle from command acceptance to the first cpu_ce=1 cycle.
- bp_match[i] = bp_en[i] && (pc == slot i), evaluated combinationally.
- brk = run_state≠HALTED && |bp_match && !bp_mask.
- cpu_ce = (run_state≠HALTED) && !brk. This is combinational, so a breakpointed instruction never executes.
- bp_mask clears after the first cycle in RUN/COUNT. Resuming from a breakpoint PC therefore executes that instruction once rather than re-hitting it.
- On brk:
  - next state HALTED;
  - bp_hit |= bp_match;
  - done pulses next cycle;
  - remaining is not decremented (no enabled cycle).
- COUNT: each cpu_ce=1 cycle decrements remaining. When remaining==1 and cpu_ce=1, next state is HALTED and done pulses next cycle. Exactly N enabled cycles occur for RUN_N N.
- Simultaneous events: a command accepted in the same cycle as brk or count expiry wins. The next state comes from the command, and no done pulse occurs. bp_hit still records the match only if brk occurred and the command is HALT.
- cycle_cnt: +1 per cpu_ce=1 cycle; holds at all-ones and never wraps. It is cleared only by reset.
- Reset mid-run: cpu_ce drops immediately (async); all state returns to reset values.
- pc changes during HALTED are ignored.

Decomposition:
- Shared package cpu_dbg_pkg holds:
  - the cmd_op encodings (OP_HALT, OP_RUN, OP_STEP, OP_RUN_N);
  - the run_state encodings (ST_HALTED, ST_RUN, ST_COUNT).
- One natural sub-module: bp_match_unit (NUM_BP parallel comparators producing bp_match). FSM, counters and mask stay in cpu_run_ctrl.

Test Plan:
1. Reset, then STEP at cycle 0 → cpu_ce=1 only in cycle 1; done=1 in cycle 2; cycle_cnt=1; run_state=0.
2. RUN_N with cmd_n=5 → cpu_ce high for exactly 5 cycles; done one pulse; cycle_cnt=5. Then RUN_N with cmd_n=0 → no cpu_ce; done pulse next cycle.
3. bp_en=01, slot0=0x0000_0010, RUN with pc advancing +4 per enabled cycle from 0 → cpu_ce=0 at pc=0x10; bp_hit=01; done pulse; cycle_cnt=4. STEP → the 0x10 instruction executes once, no re-hit; bp_hit=00.
4. Both slots = 0x20, both enabled → single halt with bp_hit=11. In the same-cycle case of HALT command plus breakpoint → no done pulse.
5. CNT_W=4 instance: RUN for 20 cycles → cycle_cnt saturates at 15.
6. rst asserted in the middle of RUN_N with cmd_n=10 → cpu_ce=0 immediately; all outputs at reset values; no done pulse after release.
